// File: rtl/fetch_redirect_if.sv
// Fetch redirect control bus: redirect requests in, fetch PC and flush controls out.
// Defining FETCH_REDIRECT_STATS_EN adds the EX/ID redirect counters to the bus.
interface fetch_redirect_if #(
    parameter int SIZE_PC = 32
);
    logic               stall;
    logic               fs2_ready;
    logic               recover_flag;
    logic [SIZE_PC-1:0] recover_pc;
    logic               flag_recover_ex;
    logic [SIZE_PC-1:0] target_addr_ex;
    logic               flag_recover_id;
    logic [SIZE_PC-1:0] target_addr_id;
    logic               btb_taken;
    logic [SIZE_PC-1:0] btb_target;
    logic [SIZE_PC-1:0] pc;
    logic               fetch_en;
    logic               flush_fs1;
    logic               flush_fs2;
    logic [2:0]         redirect_src;
    logic               pending_valid;
`ifdef FETCH_REDIRECT_STATS_EN
    logic [31:0]        ex_redirect_cnt;
    logic [31:0]        id_redirect_cnt;

    modport master (
        output stall, fs2_ready, recover_flag, recover_pc, flag_recover_ex, target_addr_ex,
               flag_recover_id, target_addr_id, btb_taken, btb_target,
        input  pc, fetch_en, flush_fs1, flush_fs2, redirect_src, pending_valid,
               ex_redirect_cnt, id_redirect_cnt
    );
    modport slave (
        input  stall, fs2_ready, recover_flag, recover_pc, flag_recover_ex, target_addr_ex,
               flag_recover_id, target_addr_id, btb_taken, btb_target,
        output pc, fetch_en, flush_fs1, flush_fs2, redirect_src, pending_valid,
               ex_redirect_cnt, id_redirect_cnt
    );
`else
    modport master (
        output stall, fs2_ready, recover_flag, recover_pc, flag_recover_ex, target_addr_ex,
               flag_recover_id, target_addr_id, btb_taken, btb_target,
        input  pc, fetch_en, flush_fs1, flush_fs2, redirect_src, pending_valid
    );
    modport slave (
        input  stall, fs2_ready, recover_flag, recover_pc, flag_recover_ex, target_addr_ex,
               flag_recover_id, target_addr_id, btb_taken, btb_target,
        output pc, fetch_en, flush_fs1, flush_fs2, redirect_src, pending_valid
    );
`endif
endinterface

// File: rtl/fetch_redirect_ctrl.sv
// Fetch PC sequencer: prioritises commit > EX > ID > BTB > sequential redirects across RUN/STALL/RECOVER.
// Optional feature macro: FETCH_REDIRECT_STATS_EN (saturating EX/ID redirect counters).
module fetch_redirect_ctrl #(
    parameter int                 SIZE_PC         = 32,
    parameter logic [SIZE_PC-1:0] RESET_PC        = '0,
    parameter int                 RECOVER_BUBBLES = 2,
    parameter int                 FETCH_STRIDE    = 32
) (
    input logic             clk,
    input logic             rst,
    fetch_redirect_if.slave bus
);
    localparam logic [1:0] RUN     = 2'd0;
    localparam logic [1:0] STALL   = 2'd1;
    localparam logic [1:0] RECOVER = 2'd2;

    localparam logic [2:0] SRC_SEQ    = 3'd0;
    localparam logic [2:0] SRC_BTB    = 3'd1;
    localparam logic [2:0] SRC_ID     = 3'd2;
    localparam logic [2:0] SRC_EX     = 3'd3;
    localparam logic [2:0] SRC_COMMIT = 3'd4;

    localparam logic [2:0]         BUBBLES = 3'(RECOVER_BUBBLES);
    localparam logic [SIZE_PC-1:0] STRIDE  = SIZE_PC'(FETCH_STRIDE);

    logic [1:0]         state, state_next;
    logic [2:0]         bubble_cnt, cnt_next;
    logic               started;
    logic [SIZE_PC-1:0] pc_q;
    logic [2:0]         src_q;
    logic               flush1_q, flush2_q;
    logic               pend_valid;
    logic [2:0]         pend_src;
    logic [SIZE_PC-1:0] pend_target;

    logic [2:0]         req_src;
    logic [SIZE_PC-1:0] req_target;
    logic               apply, latch, clear_pend, fetch_en;
    logic [2:0]         apply_src;
    logic [SIZE_PC-1:0] apply_target;

    // fetch_en is low on the first cycle after reset release so the I-cache sees a settled PC
    assign fetch_en = started && (state == RUN) && !bus.stall;

    always_comb begin
        req_src    = SRC_SEQ;
        req_target = pc_q + STRIDE;
        if (bus.recover_flag) begin
            req_src    = SRC_COMMIT;
            req_target = bus.recover_pc;
        end else if (bus.flag_recover_ex) begin
            req_src    = SRC_EX;
            req_target = bus.target_addr_ex;
        end else if (bus.flag_recover_id) begin
            req_src    = SRC_ID;
            req_target = bus.target_addr_id;
        end else if (bus.btb_taken) begin
            req_src    = SRC_BTB;
            req_target = bus.btb_target;
        end
    end

    always_comb begin
        apply        = 1'b0;
        apply_src    = req_src;
        apply_target = req_target;
        latch        = 1'b0;
        clear_pend   = 1'b0;
        state_next   = state;
        cnt_next     = bubble_cnt;
        if (state == RECOVER) begin
            if (req_src == SRC_COMMIT) begin
                apply    = 1'b1;
                cnt_next = BUBBLES;
            end else if (bubble_cnt <= 3'd1) begin
                state_next = RUN;
                cnt_next   = 3'd0;
            end else begin
                cnt_next = bubble_cnt - 3'd1;
            end
        end else if (req_src == SRC_COMMIT) begin
            apply      = 1'b1;
            clear_pend = 1'b1;
            state_next = RECOVER;
            cnt_next   = BUBBLES;
        end else if (bus.stall) begin
            state_next = STALL;
            latch      = (req_src != SRC_SEQ) && (!pend_valid || req_src >= pend_src);
        end else if (state == STALL) begin
            // a fresh EX/ID redirect on the release edge beats an older pending of lower rank
            state_next = RUN;
            clear_pend = 1'b1;
            if (req_src >= SRC_ID && (!pend_valid || req_src >= pend_src)) begin
                apply = 1'b1;
            end else if (pend_valid) begin
                apply        = 1'b1;
                apply_src    = pend_src;
                apply_target = pend_target;
            end
        end else if (req_src >= SRC_ID || (fetch_en && bus.fs2_ready)) begin
            apply = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            bubble_cnt  <= 3'd0;
            started     <= 1'b0;
            pc_q        <= RESET_PC;
            src_q       <= SRC_SEQ;
            flush1_q    <= 1'b0;
            flush2_q    <= 1'b0;
            pend_valid  <= 1'b0;
            pend_src    <= SRC_SEQ;
            pend_target <= '0;
        end else begin
            state      <= state_next;
            bubble_cnt <= cnt_next;
            started    <= 1'b1;
            flush1_q   <= apply && (apply_src >= SRC_ID);
            flush2_q   <= apply && (apply_src >= SRC_EX);
            if (apply) begin
                pc_q  <= apply_target;
                src_q <= apply_src;
            end
            if (clear_pend) begin
                pend_valid <= 1'b0;
            end else if (latch) begin
                pend_valid  <= 1'b1;
                pend_src    <= req_src;
                pend_target <= req_target;
            end
        end
    end

    assign bus.pc            = pc_q;
    assign bus.fetch_en      = fetch_en;
    assign bus.flush_fs1     = flush1_q;
    assign bus.flush_fs2     = flush2_q;
    assign bus.redirect_src  = src_q;
    assign bus.pending_valid = pend_valid;

`ifdef FETCH_REDIRECT_STATS_EN
    logic [31:0] ex_cnt, id_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_cnt <= 32'd0;
            id_cnt <= 32'd0;
        end else begin
            if (apply && apply_src == SRC_EX && ex_cnt != 32'hFFFF_FFFF) ex_cnt <= ex_cnt + 32'd1;
            if (apply && apply_src == SRC_ID && id_cnt != 32'hFFFF_FFFF) id_cnt <= id_cnt + 32'd1;
        end
    end

    assign bus.ex_redirect_cnt = ex_cnt;
    assign bus.id_redirect_cnt = id_cnt;
`endif
endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Testbench for fetch_redirect_ctrl: directed scenarios plus randomized traffic against a priority-rule model.
module tb_fetch_redirect_ctrl;
    localparam int SIZE_PC = 32;
    localparam int BUBBLES = 2;
    localparam int STRIDE  = 32;

    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    fetch_redirect_if #(.SIZE_PC(SIZE_PC)) bus ();

    fetch_redirect_ctrl #(
        .SIZE_PC(SIZE_PC), .RESET_PC(32'h0000_0000),
        .RECOVER_BUBBLES(BUBBLES), .FETCH_STRIDE(STRIDE)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    typedef enum int {M_RUN, M_STALL, M_RECOVER} mode_t;

    mode_t       m_mode;
    logic [31:0] m_pc, m_pend_tgt;
    int          m_src, m_pend_src, m_dead;
    bit          m_pend, m_f1, m_f2, m_started;
    longint      m_ex, m_id;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        m_mode = M_RUN; m_pc = 32'h0; m_src = 0; m_pend = 0; m_pend_src = 0; m_pend_tgt = 0;
        m_f1 = 0; m_f2 = 0; m_dead = 0; m_started = 0; m_ex = 0; m_id = 0;
    endtask

    function automatic bit expFetch();
        return m_started && (m_mode == M_RUN) && !bus.stall;
    endfunction

    // One clock of the reference: pick the strongest live request, then apply the mode rules
    task automatic modelStep();
        int          req, use_src;
        logic [31:0] tgt, use_tgt;
        bit          take;
        req = 0; tgt = m_pc + 32'(STRIDE);
        if (bus.btb_taken)       begin req = 1; tgt = bus.btb_target;     end
        if (bus.flag_recover_id) begin req = 2; tgt = bus.target_addr_id; end
        if (bus.flag_recover_ex) begin req = 3; tgt = bus.target_addr_ex; end
        if (bus.recover_flag)    begin req = 4; tgt = bus.recover_pc;     end
        take = 0; use_src = req; use_tgt = tgt;
        if (m_mode == M_RECOVER) begin
            if (req == 4) begin take = 1; m_dead = BUBBLES; end
            else begin m_dead--; if (m_dead == 0) m_mode = M_RUN; end
        end else if (req == 4) begin
            take = 1; m_pend = 0; m_mode = M_RECOVER; m_dead = BUBBLES;
        end else if (bus.stall) begin
            m_mode = M_STALL;
            if (req > 0 && (!m_pend || req >= m_pend_src)) begin
                m_pend = 1; m_pend_src = req; m_pend_tgt = tgt;
            end
        end else if (m_mode == M_STALL) begin
            m_mode = M_RUN;
            if (req >= 2 && (!m_pend || req >= m_pend_src)) take = 1;
            else if (m_pend) begin take = 1; use_src = m_pend_src; use_tgt = m_pend_tgt; end
            m_pend = 0;
        end else if (req >= 2 || (m_started && bus.fs2_ready)) begin
            take = 1;
        end
        m_f1 = take && use_src >= 2;
        m_f2 = take && use_src >= 3;
        if (take) begin
            m_pc = use_tgt; m_src = use_src;
            if (use_src == 3) m_ex++;
            if (use_src == 2) m_id++;
        end
        m_started = 1;
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".pc"}, 64'(bus.pc), 64'(m_pc));
        checkOutput({tag, ".src"}, 64'(bus.redirect_src), 64'(m_src));
        checkOutput({tag, ".flush1"}, 64'(bus.flush_fs1), 64'(m_f1));
        checkOutput({tag, ".flush2"}, 64'(bus.flush_fs2), 64'(m_f2));
        checkOutput({tag, ".pending"}, 64'(bus.pending_valid), 64'(m_pend));
`ifdef FETCH_REDIRECT_STATS_EN
        checkOutput({tag, ".excnt"}, 64'(bus.ex_redirect_cnt), 64'(m_ex));
        checkOutput({tag, ".idcnt"}, 64'(bus.id_redirect_cnt), 64'(m_id));
`endif
    endtask

    // Drive one cycle of inputs, check fetch_en, clock it, then check the registered outputs
    task automatic applyStimulus(input bit st, input bit rd, input bit rc, input logic [31:0] rcpc,
                                 input bit ex, input logic [31:0] ext, input bit id, input logic [31:0] idt,
                                 input bit bt, input logic [31:0] btt);
        bus.stall = st; bus.fs2_ready = rd;
        bus.recover_flag = rc; bus.recover_pc = rcpc;
        bus.flag_recover_ex = ex; bus.target_addr_ex = ext;
        bus.flag_recover_id = id; bus.target_addr_id = idt;
        bus.btb_taken = bt; bus.btb_target = btt;
        #1;
        checkOutput("fetch_en", 64'(bus.fetch_en), 64'(expFetch()));
        modelStep();
        @(posedge clk);
        #1;
        checkAll("cyc");
    endtask

    task automatic idle(input int n, input bit st);
        for (int i = 0; i < n; i++) applyStimulus(st, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic doReset();
        rst = 1'b1;
        bus.stall = 0; bus.fs2_ready = 0; bus.recover_flag = 0; bus.recover_pc = 0;
        bus.flag_recover_ex = 0; bus.target_addr_ex = 0; bus.flag_recover_id = 0;
        bus.target_addr_id = 0; bus.btb_taken = 0; bus.btb_target = 0;
        #1;
        modelReset();
        checkAll("rst");
        checkOutput("rst.fetch_en", 64'(bus.fetch_en), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        doReset();

        // sequential run from reset
        idle(4, 0);
        checkOutput("seq.pc", 64'(bus.pc), 64'h60);

        // EX beats ID in the same cycle
        applyStimulus(0, 1, 0, 0, 1, 32'h400, 1, 32'h800, 0, 0);
        checkOutput("exid.pc", 64'(bus.pc), 64'h400);
        checkOutput("exid.src", 64'(bus.redirect_src), 64'd3);
        checkOutput("exid.flush", 64'({bus.flush_fs1, bus.flush_fs2}), 64'b11);
        idle(1, 0);
        checkOutput("exid.pulse", 64'({bus.flush_fs1, bus.flush_fs2}), 64'b00);

        // pending during stall: ID, then EX overwrites, BTB dropped
        applyStimulus(1, 1, 0, 0, 0, 0, 1, 32'h100, 0, 0);
        applyStimulus(1, 1, 0, 0, 1, 32'h200, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 1, 32'h300);
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("stall.pending", 64'(bus.pending_valid), 64'd1);
        idle(1, 0);
        checkOutput("stall.release_pc", 64'(bus.pc), 64'h200);
        checkOutput("stall.cleared", 64'(bus.pending_valid), 64'd0);
        idle(2, 0);

        // commit recovery with two dead cycles
        applyStimulus(0, 1, 1, 32'h1000, 1, 32'h500, 0, 0, 0, 0);
        checkOutput("rec.pc", 64'(bus.pc), 64'h1000);
        idle(3, 0);
        checkOutput("rec.advance", 64'(bus.pc), 64'h1020);

        // commit recovery while stalled with an ID pending
        applyStimulus(1, 1, 0, 0, 0, 0, 1, 32'h100, 0, 0);
        applyStimulus(1, 1, 1, 32'h1000, 0, 0, 0, 0, 0, 0);
        checkOutput("recst.pc", 64'(bus.pc), 64'h1000);
        checkOutput("recst.pending", 64'(bus.pending_valid), 64'd0);
        idle(1, 0);
        checkOutput("recst.dead", 64'(bus.fetch_en), 64'd0);
        idle(2, 0);

        // wrap at the top of the address space
        applyStimulus(0, 1, 1, 32'hFFFF_FFE0, 0, 0, 0, 0, 0, 0);
        idle(3, 0);
        checkOutput("wrap.pc", 64'(bus.pc), 64'h0);

        // randomized traffic with occasional mid-flight resets
        for (int n = 0; n < 3000; n++) begin
            if (n % 700 == 699) doReset();
            applyStimulus($urandom_range(99) < 25, $urandom_range(99) < 75,
                          $urandom_range(99) < 3,  $urandom() & 32'hFFFF_FFE0,
                          $urandom_range(99) < 8,  $urandom() & 32'hFFFF_FFE0,
                          $urandom_range(99) < 8,  $urandom() & 32'hFFFF_FFE0,
                          $urandom_range(99) < 15, $urandom() & 32'hFFFF_FFE0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
